// File: rtl/seq_scan_controller.sv
// seq_scan_controller: walks one shared sequence_detector through a per-pattern scan of a latched word.
// Optional feature macro SEQ_SCAN_FIRST_HIT_EN adds res_first_hit (first detector hit offset per pattern).
module seq_scan_controller #(
  parameter int MAX_LEN = 32,
  parameter int CNT_W   = 16,
  parameter int SETTLE  = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [MAX_LEN-1:0] data_in,
  input  logic [5:0]         data_len,
  input  logic [3:0]         pattern_mask,
  output logic               busy,
  output logic               done,
  output logic               res_valid,
  output logic [1:0]         res_pattern,
  output logic [CNT_W-1:0]   res_count,
  output logic               det_input_seq,
  output logic               det_reset,
  output logic [1:0]         det_lookfor_seq,
  input  logic               det_seq_detected,
  input  logic [CNT_W-1:0]   det_seq_count
`ifdef SEQ_SCAN_FIRST_HIT_EN
  ,
  output logic [5:0]         res_first_hit
`endif
);

  localparam logic [5:0] LEN_CAP     = (MAX_LEN > 63) ? 6'd63 : 6'(MAX_LEN);
  localparam logic [5:0] SETTLE_LAST = 6'(SETTLE - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_SHIFT,
    ST_SETTLE,
    ST_REPORT,
    ST_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [MAX_LEN-1:0]   data_q, data_d;
  logic [MAX_LEN-1:0]   shreg_q, shreg_d;
  logic [5:0]           len_q, len_d;
  logic [3:0]           rem_q, rem_d;
  logic [1:0]           pat_q, pat_d;
  logic [5:0]           cnt_q, cnt_d;
  logic [1:0]           res_pattern_q, res_pattern_d;
  logic [CNT_W-1:0]     res_count_q, res_count_d;

  logic [5:0]           len_clamped;
  logic [1:0]           start_lo;
  logic [1:0]           rem_lo;

  function automatic logic [1:0] low_bit(input logic [3:0] m);
    if (m[0])      return 2'd0;
    else if (m[1]) return 2'd1;
    else if (m[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  assign len_clamped = (32'(data_len) > 32'(MAX_LEN)) ? LEN_CAP : data_len;
  assign start_lo    = low_bit(pattern_mask);
  assign rem_lo      = low_bit(rem_q);

  always_comb begin
    state_d       = state_q;
    data_d        = data_q;
    shreg_d       = shreg_q;
    len_d         = len_q;
    rem_d         = rem_q;
    pat_d         = pat_q;
    cnt_d         = cnt_q;
    res_pattern_d = res_pattern_q;
    res_count_d   = res_count_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          data_d = data_in;
          len_d  = len_clamped;
          if (len_clamped == 6'd0 || pattern_mask == 4'd0) begin
            state_d = ST_DONE;
          end else begin
            pat_d   = start_lo;
            rem_d   = pattern_mask & ~(4'b0001 << start_lo);
            state_d = ST_CLR;
          end
        end
      end
      ST_CLR: begin
        // Reload the serializer from the latched word so every pattern sees identical bits.
        shreg_d = data_q;
        cnt_d   = 6'd0;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        shreg_d = shreg_q >> 1;
        if (cnt_q == 6'(len_q - 6'd1)) begin
          cnt_d   = 6'd0;
          state_d = ST_SETTLE;
        end else begin
          cnt_d = 6'(cnt_q + 6'd1);
        end
      end
      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = ST_REPORT;
        end else begin
          cnt_d = 6'(cnt_q + 6'd1);
        end
      end
      ST_REPORT: begin
        res_pattern_d = pat_q;
        res_count_d   = det_seq_count;
        if (rem_q != 4'd0) begin
          pat_d   = rem_lo;
          rem_d   = rem_q & ~(4'b0001 << rem_lo);
          state_d = ST_CLR;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      data_q        <= '0;
      shreg_q       <= '0;
      len_q         <= '0;
      rem_q         <= '0;
      pat_q         <= '0;
      cnt_q         <= '0;
      res_pattern_q <= '0;
      res_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      data_q        <= data_d;
      shreg_q       <= shreg_d;
      len_q         <= len_d;
      rem_q         <= rem_d;
      pat_q         <= pat_d;
      cnt_q         <= cnt_d;
      res_pattern_q <= res_pattern_d;
      res_count_q   <= res_count_d;
    end
  end

  // Results are visible combinationally in REPORT, then held from the capture registers.
  assign busy            = (state_q != ST_IDLE);
  assign done            = (state_q == ST_DONE);
  assign res_valid       = (state_q == ST_REPORT);
  assign res_pattern     = res_valid ? pat_q : res_pattern_q;
  assign res_count       = res_valid ? det_seq_count : res_count_q;
  assign det_input_seq   = (state_q == ST_SHIFT) & shreg_q[0];
  assign det_reset       = reset | (state_q == ST_CLR);
  assign det_lookfor_seq = pat_q;

`ifdef SEQ_SCAN_FIRST_HIT_EN
  localparam logic [5:0] NO_HIT  = 6'h3F;
  localparam logic [5:0] OFF_SAT = 6'd62;

  logic [5:0] off_q, off_d;
  logic [5:0] first_q, first_d;
  logic [5:0] res_first_q, res_first_d;

  always_comb begin
    off_d       = off_q;
    first_d     = first_q;
    res_first_d = res_first_q;
    case (state_q)
      ST_CLR: begin
        off_d   = 6'd0;
        first_d = NO_HIT;
      end
      ST_SHIFT, ST_SETTLE: begin
        if (det_seq_detected && first_q == NO_HIT) begin
          first_d = off_q;
        end
        if (off_q != OFF_SAT) begin
          off_d = 6'(off_q + 6'd1);
        end
      end
      ST_REPORT: begin
        res_first_d = first_q;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      off_q       <= '0;
      first_q     <= NO_HIT;
      res_first_q <= NO_HIT;
    end else begin
      off_q       <= off_d;
      first_q     <= first_d;
      res_first_q <= res_first_d;
    end
  end

  assign res_first_hit = res_valid ? first_q : res_first_q;
`else
  logic unused_det_hit;
  assign unused_det_hit = det_seq_detected;
`endif

endmodule
